// File: rtl/servo_pwm_multi_if.sv
// Command handshake between the SPI decode path (master) and the servo PWM block (slave).
interface servo_pwm_multi_if #(
   parameter int NUM_CH = 2,
   parameter int CMD_W  = 11
) ();
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]  cmd_ch;
   logic [CMD_W-1:0] cmd_val;
   logic             cmd_valid;
   logic             cmd_ready;

   modport master (output cmd_ch, output cmd_val, output cmd_valid, input cmd_ready);
   modport slave  (input cmd_ch, input cmd_val, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared tick/frame counter, per-channel command staging
// applied at frame boundaries, optional per-frame slew limit.
module servo_pwm_multi #(
   parameter int NUM_CH  = 2,
   parameter int CLK_DIV = 100,
   parameter int PERIOD  = 20000,
   parameter int MIN_PW  = 1000,
   parameter int CMD_MAX = 1000,
   parameter int CMD_W   = 11,
   parameter int SLEW    = 0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   servo_pwm_multi_if.slave    cmd,
   input  logic [NUM_CH-1:0]   ch_en_i,
   output logic [NUM_CH-1:0]   pwm_o,
   output logic                frame_start_o
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PRE_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(PERIOD);
   localparam int CMP_W = CNT_W + 1;
   localparam int SW    = CMD_W + 1;

   localparam logic [CMD_W-1:0]     CENTRE    = CMD_W'(CMD_MAX / 2);
   localparam logic [CMD_W-1:0]     CMD_MAX_V = CMD_W'(CMD_MAX);
   localparam logic signed [SW-1:0] SLEW_P    = SW'(SLEW);
   localparam logic signed [SW-1:0] SLEW_N    = -SW'(SLEW);

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CMD_W-1:0]  target_q [NUM_CH];
   logic [CMD_W-1:0]  target_d [NUM_CH];
   logic [CMD_W-1:0]  active_q [NUM_CH];
   logic [CMD_W-1:0]  active_d [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              fs_q;

   logic                tick, bnd, xfer;
   logic [CMD_W-1:0]    cmd_clamped;
   logic signed [SW-1:0] diff [NUM_CH];
   logic signed [SW-1:0] step [NUM_CH];
   logic [CMP_W-1:0]    thr  [NUM_CH];

   always_comb begin
      tick  = (pre_q == PRE_W'(CLK_DIV - 1));
      bnd   = tick && (cnt_q == CNT_W'(PERIOD - 1));
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      cnt_d = cnt_q;
      if (tick) begin
         cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // No transfer is taken on the boundary cycle, so the staged targets are stable when copied.
   assign cmd.cmd_ready = rst_ni & ~bnd;
   assign xfer          = cmd.cmd_valid & cmd.cmd_ready;
   assign cmd_clamped   = (cmd.cmd_val > CMD_MAX_V) ? CMD_MAX_V : cmd.cmd_val;

   // Out-of-range channel numbers match no iteration and are silently dropped.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         target_d[c] = target_q[c];
         if (xfer && (cmd.cmd_ch == CH_W'(c))) begin
            target_d[c] = cmd_clamped;
         end
      end
   end

   always_comb begin
      en_d = bnd ? ch_en_i : en_q;
      for (int c = 0; c < NUM_CH; c++) begin
         diff[c] = $signed({1'b0, target_q[c]}) - $signed({1'b0, active_q[c]});
         step[c] = diff[c];
         if (diff[c] > SLEW_P) begin
            step[c] = SLEW_P;
         end else if (diff[c] < SLEW_N) begin
            step[c] = SLEW_N;
         end
         active_d[c] = active_q[c];
         if (bnd) begin
            if (SLEW == 0) begin
               active_d[c] = target_q[c];
            end else begin
               active_d[c] = CMD_W'($signed({1'b0, active_q[c]}) + step[c]);
            end
         end
      end
   end

   // Compare against next-state values so pwm edges line up with the counter.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         thr[c]   = CMP_W'(MIN_PW) + CMP_W'(active_d[c]);
         pwm_d[c] = en_d[c] && ({1'b0, cnt_d} < thr[c]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q <= '0;
         cnt_q <= '0;
         en_q  <= '0;
         pwm_q <= '0;
         fs_q  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            target_q[c] <= CENTRE;
            active_q[c] <= CENTRE;
         end
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         en_q  <= en_d;
         pwm_q <= pwm_d;
         fs_q  <= bnd;
         for (int c = 0; c < NUM_CH; c++) begin
            target_q[c] <= target_d[c];
            active_q[c] <= active_d[c];
         end
      end
   end

   assign pwm_o         = pwm_q;
   assign frame_start_o = fs_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (no slew / slew 4) driven identically and
// compared each cycle against a frame-level reference model, plus directed pulse-width checks.
module tb_servo_pwm_multi;
   localparam int NCH     = 3;
   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 50;
   localparam int MIN_PW  = 10;
   localparam int CMD_MAX = 20;
   localparam int CMD_W   = 5;
   localparam int FR      = PERIOD * CLK_DIV;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] pwm0, pwm1;
   logic           fs0, fs1;

   servo_pwm_multi_if #(.NUM_CH(NCH), .CMD_W(CMD_W)) if0 ();
   servo_pwm_multi_if #(.NUM_CH(NCH), .CMD_W(CMD_W)) if1 ();

   servo_pwm_multi #(.NUM_CH(NCH), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .MIN_PW(MIN_PW),
                     .CMD_MAX(CMD_MAX), .CMD_W(CMD_W), .SLEW(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .cmd(if0), .ch_en_i(ch_en),
      .pwm_o(pwm0), .frame_start_o(fs0));

   servo_pwm_multi #(.NUM_CH(NCH), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .MIN_PW(MIN_PW),
                     .CMD_MAX(CMD_MAX), .CMD_W(CMD_W), .SLEW(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .cmd(if1), .ch_en_i(ch_en),
      .pwm_o(pwm1), .frame_start_o(fs1));

   always #5 clk = ~clk;

   int   vectors = 0;
   int   errors  = 0;
   int   k;
   int   m_tgt [2][NCH];
   int   m_act [2][NCH];
   bit   m_en  [2][NCH];
   int   hi    [2][NCH];
   int   wid   [2][NCH];
   logic       v;
   logic [1:0] cch;
   logic [4:0] cval;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic drive(bit valid, int ch, int val);
      v    = valid;
      cch  = 2'(ch);
      cval = 5'(val);
      if0.cmd_valid = valid; if0.cmd_ch = 2'(ch); if0.cmd_val = 5'(val);
      if1.cmd_valid = valid; if1.cmd_ch = 2'(ch); if1.cmd_val = 5'(val);
   endtask

   function automatic int slew_of(int d);
      return (d == 0) ? 0 : 4;
   endfunction

   function automatic int move(int act, int tgt, int s);
      int dlt;
      if (s == 0) return tgt;
      dlt = tgt - act;
      if (dlt > s)  dlt = s;
      if (dlt < -s) dlt = -s;
      return act + dlt;
   endfunction

   function automatic logic get_pwm(int d, int c);
      return (d == 0) ? pwm0[c] : pwm1[c];
   endfunction

   task automatic model_reset();
      k = 0;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++) begin
            m_tgt[d][c] = CMD_MAX / 2;
            m_act[d][c] = CMD_MAX / 2;
            m_en[d][c]  = 1'b0;
            hi[d][c]    = 0;
            wid[d][c]   = 0;
         end
   endtask

   // Compare every observable of the current cycle k against the model.
   task automatic check_cycle();
      int  cnt;
      bit  fs_exp, rdy_exp, p_exp;
      cnt     = (k / CLK_DIV) % PERIOD;
      fs_exp  = (k % FR == 0) && (k > 0);
      rdy_exp = (k % FR != FR - 1);
      check("frame_start0", 32'(fs0), 32'(fs_exp));
      check("frame_start1", 32'(fs1), 32'(fs_exp));
      check("cmd_ready0", 32'(if0.cmd_ready), 32'(rdy_exp));
      check("cmd_ready1", 32'(if1.cmd_ready), 32'(rdy_exp));
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++) begin
            p_exp = m_en[d][c] && (cnt < MIN_PW + m_act[d][c]);
            check($sformatf("pwm d%0d ch%0d", d, c), 32'(get_pwm(d, c)), 32'(p_exp));
            if (fs_exp) begin
               wid[d][c] = hi[d][c];
               hi[d][c]  = 0;
            end
            if (get_pwm(d, c) === 1'b1) hi[d][c]++;
         end
   endtask

   task automatic step();
      bit bnd;
      @(posedge clk);
      bnd = (k % FR == FR - 1);
      for (int d = 0; d < 2; d++) begin
         if (v && !bnd && cch < NCH)
            m_tgt[d][cch] = (cval > CMD_MAX) ? CMD_MAX : int'(cval);
         if (bnd)
            for (int c = 0; c < NCH; c++) begin
               m_en[d][c]  = ch_en[c];
               m_act[d][c] = move(m_act[d][c], m_tgt[d][c], slew_of(d));
            end
      end
      k++;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic to_fs();
      do step(); while (k % FR != 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst pwm0", 32'(pwm0), 32'(0));
      check("rst pwm1", 32'(pwm1), 32'(0));
      check("rst ready0", 32'(if0.cmd_ready), 32'(0));
      check("rst fs0", 32'(fs0), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      check_cycle();
   endtask

   task automatic wchk(string tag, int d, int c, int exp);
      check(tag, 32'(wid[d][c]), 32'(exp));
   endtask

   initial begin
      ch_en = 3'b111;
      drive(0, 0, 0);
      model_reset();
      do_reset();

      // reset / first frames
      to_fs();
      for (int c = 0; c < NCH; c++) wchk("first frame dark", 0, c, 0);
      to_fs();
      for (int c = 0; c < NCH; c++) wchk("centre width", 0, c, 40);
      run(5);
      check("pwm high before reset", 32'(pwm0), 32'(3'b111));
      do_reset();
      to_fs();
      for (int c = 0; c < NCH; c++) wchk("post-reset frame dark", 0, c, 0);
      to_fs();
      for (int c = 0; c < NCH; c++) wchk("post-reset centre", 0, c, 40);

      // command update mid-frame
      run(30);
      drive(1, 1, 20); step(); drive(0, 0, 0);
      to_fs();
      wchk("cmd frame unchanged", 0, 1, 40);
      to_fs();
      wchk("ch1 new width", 0, 1, 60);
      wchk("ch0 untouched", 0, 0, 40);
      wchk("ch2 untouched", 0, 2, 40);
      wchk("ch1 slewed", 1, 1, 48);

      // clamp and discard
      run(20);
      drive(1, 2, 31); step();
      drive(1, 3, 0);
      check("discard ready", 32'(if0.cmd_ready), 32'(1));
      step(); drive(0, 0, 0);
      to_fs();
      run(30);
      drive(1, 0, 0); step(); drive(0, 0, 0);
      to_fs();
      wchk("clamp ch2", 0, 2, 60);
      wchk("discard ch0", 0, 0, 40);
      wchk("slew start", 1, 0, 40);
      to_fs();
      wchk("slew f1", 1, 0, 32);
      wchk("noslew ch0", 0, 0, 20);
      to_fs();
      wchk("slew f2", 1, 0, 24);
      to_fs();
      wchk("slew f3", 1, 0, 20);
      to_fs();
      wchk("slew f4", 1, 0, 20);

      // boundary collision
      run(FR - 1);
      drive(1, 1, 0);
      check("bnd ready low", 32'(if0.cmd_ready), 32'(0));
      step();
      check("post-bnd ready", 32'(if0.cmd_ready), 32'(1));
      step(); drive(0, 0, 0);
      to_fs();
      wchk("collision old value", 0, 1, 60);
      to_fs();
      wchk("collision new value", 0, 1, 20);

      // enable drop mid-pulse and raise mid-frame
      run(5);
      ch_en = 3'b110;
      to_fs();
      wchk("drop keeps pulse", 0, 0, 20);
      to_fs();
      wchk("disabled frame", 0, 0, 0);
      run(30);
      ch_en = 3'b111;
      to_fs();
      wchk("no runt pulse", 0, 0, 0);
      to_fs();
      wchk("pulse resumes", 0, 0, 20);

      // randomized traffic
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 9) == 0)
            drive(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
         else
            drive(0, 0, 0);
         if ($urandom_range(0, 149) == 0) ch_en = 3'($urandom_range(0, 7));
         step();
      end
      drive(0, 0, 0);
      run(2 * FR);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
